// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Connects a CPU request/acknowledge port to an asynchronous SRAM. One
// address (IO_ADDR) is memory-mapped to a switch input and a hex display
// register instead of the SRAM.
//
// Optional feature: define MEM_IO_BRIDGE_BYTE_EN to add the 2-bit BE port,
// which drives the byte-lane strobes. It requires DATA_W >= 16.
//
// Ports
//   Clk, Reset        clock; asynchronous active-high reset
//   Req, Wr, Addr     CPU request. Wr, Addr and WData are sampled with Req,
//   WData             and Req is held high until Ack.
//   BE                byte enables (only with MEM_IO_BRIDGE_BYTE_EN)
//   Ack, RData        one-cycle completion pulse; read data, held between Acks
//   Switches, Hex     I/O read source; I/O display register
//   CE OE WE UB LB    active-low SRAM controls
//   SRAM_ADDR         SRAM address, holds its value when idle
//   SRAM_Dout(_EN)    write data to the SRAM and its tristate enable
//   SRAM_Din          read data from the SRAM
//
// state  | meaning
// IDLE   | waiting for Req; captures the request
// SETUP  | address setup; an I/O access completes here
// ACCESS | WAIT_CYCLES strobe cycles, counted down
// DONE   | Ack pulse; write data is still driven for hold time
module mem_io_bridge #(
    parameter int              ADDR_W      = 20,
    parameter int              DATA_W      = 16,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR   = '1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
`ifdef MEM_IO_BRIDGE_BYTE_EN
    input  logic [1:0]        BE,
`endif
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] Hex,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_Dout,
    output logic              SRAM_Dout_EN,
    input  logic [DATA_W-1:0] SRAM_Din
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              wr_q;
    logic              is_io_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] hex_wr;
    logic              lanes_none;
    logic              last_access;
    logic              sram_act;

`ifdef MEM_IO_BRIDGE_BYTE_EN
    logic [1:0]        be_q;

    always_comb begin
        hex_wr = Hex;
        if (be_q[0]) hex_wr[7:0]        = wdata_q[7:0];
        if (be_q[1]) hex_wr[DATA_W-1:8] = wdata_q[DATA_W-1:8];
    end

    assign lanes_none = (be_q == 2'b00);
`else
    assign hex_wr     = wdata_q;
    assign lanes_none = 1'b0;
`endif

    assign last_access = (cnt == 4'd1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            is_io_q   <= 1'b0;
            wdata_q   <= '0;
            RData     <= '0;
            Hex       <= '0;
            SRAM_ADDR <= '0;
`ifdef MEM_IO_BRIDGE_BYTE_EN
            be_q      <= 2'b11;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Req) begin
                        wr_q    <= Wr;
                        wdata_q <= WData;
                        is_io_q <= (Addr == IO_ADDR);
                        // I/O accesses leave the SRAM address bus untouched.
                        if (Addr != IO_ADDR) SRAM_ADDR <= Addr;
`ifdef MEM_IO_BRIDGE_BYTE_EN
                        be_q    <= BE;
`endif
                    end
                end
                SETUP: begin
                    if (is_io_q) begin
                        if (wr_q) Hex   <= hex_wr;
                        else      RData <= Switches;
                    end else begin
                        cnt <= WAIT_LD;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (last_access && !wr_q) RData <= SRAM_Din;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Req) state_nxt = SETUP;
            SETUP:   state_nxt = (is_io_q || lanes_none) ? DONE : ACCESS;
            ACCESS:  if (last_access) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The controls decode directly from the state register, so an
    // asynchronous reset releases the SRAM bus in the same cycle.
    assign sram_act     = ((state == SETUP) && !is_io_q) || (state == ACCESS);
    assign CE           = ~sram_act;
    assign OE           = ~(sram_act && !wr_q);
    assign WE           = ~((state == ACCESS) && wr_q);
    // Write data is driven from SETUP through DONE. That covers address
    // setup before WE falls and data hold after WE rises.
    assign SRAM_Dout_EN = wr_q && (sram_act || ((state == DONE) && !is_io_q));
    assign SRAM_Dout    = wdata_q;
    assign Ack          = (state == DONE);

`ifdef MEM_IO_BRIDGE_BYTE_EN
    assign UB = CE | ~be_q[1];
    assign LB = CE | ~be_q[0];
`else
    assign UB = CE;
    assign LB = CE;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] switches;
    logic [15:0] hex;
    logic        ce, oe, we, ub, lb;
    logic [19:0] sram_addr;
    logic [15:0] sram_dout;
    logic        sram_dout_en;
    logic [15:0] sram_din;
`ifdef MEM_IO_BRIDGE_BYTE_EN
    logic [1:0]  be;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_io_bridge dut (
        .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .WData(wdata),
`ifdef MEM_IO_BRIDGE_BYTE_EN
        .BE(be),
`endif
        .Ack(ack), .RData(rdata), .Switches(switches), .Hex(hex),
        .CE(ce), .OE(oe), .WE(we), .UB(ub), .LB(lb),
        .SRAM_ADDR(sram_addr), .SRAM_Dout(sram_dout),
        .SRAM_Dout_EN(sram_dout_en), .SRAM_Din(sram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple asynchronous SRAM: 256 words, indexed by the low address byte.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!ce && !we) mem[sram_addr[7:0]] <= sram_dout;
    end
    assign sram_din = (!ce && !oe) ? mem[sram_addr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and samples every cycle on the falling edge.
    // Cycle 1 is the cycle in which Req is first seen high.
    task automatic access(input logic w, input logic [19:0] a, input logic [15:0] d,
                          output int ack_n, output int we_lo, output int oe_lo,
                          output int ce_lo, output int en_hi);
        ack_n = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; en_hi = 0;
        @(posedge clk); #1;
        req = 1'b1; wr = w; addr = a; wdata = d;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!we)         we_lo++;
            if (!oe)         oe_lo++;
            if (!ce)         ce_lo++;
            if (sram_dout_en) en_hi++;
            if (ack) begin
                ack_n = n;
                break;
            end
        end
        req = 1'b0;
    endtask

    int ack_n, we_lo, oe_lo, ce_lo, en_hi;
    int n1, n2, acks;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        switches = 16'h0000;
`ifdef MEM_IO_BRIDGE_BYTE_EN
        be = 2'b11;
`endif
        repeat (2) @(negedge clk);
        check("rst_ce", ce, 1'b1);
        check("rst_oe", oe, 1'b1);
        check("rst_we", we, 1'b1);
        check("rst_ublb", {ub, lb}, 2'b11);
        check("rst_en", sram_dout_en, 1'b0);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_hex", hex, 16'h0000);
        check("rst_addr", sram_addr, 20'h00000);
        rst = 1'b0;

        // SRAM write
        access(1'b1, 20'h00010, 16'hBEEF, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("wr_ack_cycle", ack_n, 5);
        check("wr_we_low", we_lo, 2);
        check("wr_oe_low", oe_lo, 0);
        check("wr_ce_low", ce_lo, 3);
        check("wr_en_high", en_hi, 4);
        check("wr_sram_addr", sram_addr, 20'h00010);
        check("wr_sram_dout", sram_dout, 16'hBEEF);

        // SRAM read of the same word
        access(1'b0, 20'h00010, 16'h0000, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("rd_ack_cycle", ack_n, 5);
        check("rd_rdata", rdata, 16'hBEEF);
        check("rd_oe_low", oe_lo, 3);
        check("rd_we_low", we_lo, 0);
        check("rd_en_high", en_hi, 0);

        // I/O read
        switches = 16'h1234;
        access(1'b0, 20'hFFFFF, 16'h0000, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("io_rd_ack_cycle", ack_n, 3);
        check("io_rd_rdata", rdata, 16'h1234);
        check("io_rd_ce_low", ce_lo, 0);
        check("io_rd_sram_addr", sram_addr, 20'h00010);

        // I/O write
`ifdef MEM_IO_BRIDGE_BYTE_EN
        be = 2'b11;
        access(1'b1, 20'hFFFFF, 16'hFFFF, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("io_wr_full_hex", hex, 16'hFFFF);
        be = 2'b01;
        access(1'b1, 20'hFFFFF, 16'hC0DE, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("io_wr_be01_hex", hex, 16'hFFDE);
        be = 2'b11;
`else
        access(1'b1, 20'hFFFFF, 16'hC0DE, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("io_wr_hex", hex, 16'hC0DE);
`endif
        check("io_wr_ack_cycle", ack_n, 3);
        check("io_wr_ce_low", ce_lo, 0);
        check("io_wr_en_high", en_hi, 0);

        // Back-to-back reads with Req held through Ack
        n1 = 0; n2 = 0;
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 20'h00010;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ack) begin
                if (n1 == 0) n1 = n;
                else begin
                    n2 = n;
                    break;
                end
            end
        end
        req = 1'b0;
        check("b2b_first_ack", n1, 5);
        check("b2b_ack_spacing", n2 - n1, 5);
        check("b2b_rdata", rdata, 16'hBEEF);

        // Reset during the ACCESS phase of a write
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; addr = 20'h00020; wdata = 16'h1111;
        repeat (3) @(negedge clk);
        check("abort_we_before", we, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_we", we, 1'b1);
        check("abort_en", sram_dout_en, 1'b0);
        check("abort_ce", ce, 1'b1);
        check("abort_ack", ack, 1'b0);
        check("abort_addr", sram_addr, 20'h00000);
        check("abort_rdata", rdata, 16'h0000);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_no_ack", acks, 0);

        access(1'b1, 20'h00030, 16'h5A5A, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("post_rst_ack_cycle", ack_n, 5);
        check("post_rst_we_low", we_lo, 2);
        access(1'b0, 20'h00030, 16'h0000, ack_n, we_lo, oe_lo, ce_lo, en_hi);
        check("post_rst_rdata", rdata, 16'h5A5A);
        check("post_rst_addr", sram_addr, 20'h00030);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
